// File: rtl/stage_swap_pkg.sv
// Shared encodings for the stage_swap_pipe register pipeline: run modes,
// controller states, per-cell source selects and the decoded per-edge operation.
package stage_swap_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_SWAP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD    = 2'd0,
    SEL_PREV    = 2'd1,
    SEL_WRAP    = 2'd2,
    SEL_PARTNER = 2'd3
  } cell_sel_t;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_SHIFT  = 3'd2,
    OP_ROTATE = 3'd3,
    OP_SWAP   = 3'd4
  } op_t;

endpackage

// File: rtl/swap_pipe_cell.sv
// One pipeline stage: WIDTH-bit data plus valid flag, with parallel load and a
// 4-way source mux (hold / previous stage / wrap-around / swap partner).
module swap_pipe_cell
  import stage_swap_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  cell_sel_t        sel_i,
  input  logic [WIDTH-1:0] prev_data_i,
  input  logic             prev_vld_i,
  input  logic [WIDTH-1:0] wrap_data_i,
  input  logic             wrap_vld_i,
  input  logic [WIDTH-1:0] partner_data_i,
  input  logic             partner_vld_i,
  output logic [WIDTH-1:0] data_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (load_i) begin
      data_d = load_data_i;
      vld_d  = 1'b1;
    end else begin
      case (sel_i)
        SEL_PREV: begin
          data_d = prev_data_i;
          vld_d  = prev_vld_i;
        end
        SEL_WRAP: begin
          data_d = wrap_data_i;
          vld_d  = wrap_vld_i;
        end
        SEL_PARTNER: begin
          data_d = partner_data_i;
          vld_d  = partner_vld_i;
        end
        default: begin
          data_d = data_q;
          vld_d  = vld_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/stage_swap_pipe.sv
// DEPTH-stage register pipeline with hold/shift/rotate/swap modes, parallel
// load, per-stage valids, a fill counter and a drain controller with done pulse.
module stage_swap_pipe
  import stage_swap_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  input  logic                       load,
  input  logic [WIDTH*DEPTH-1:0]     load_data,
  input  logic                       drain,
  output logic [WIDTH*DEPTH-1:0]     stages,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH+1)-1:0] fill_count,
  output logic                       busy,
  output logic                       done
);

  localparam int FW = $clog2(DEPTH+1);

  state_t           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             busy_q, done_q, done_d;
  op_t              op;
  logic [WIDTH-1:0] shift_din;
  logic             shift_vld;

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_vld;

  // Operation decode: drain forces a zero-filled shift and masks all other requests.
  always_comb begin
    op        = OP_NONE;
    shift_din = din;
    shift_vld = din_valid;
    if (state_q == ST_DRAIN) begin
      op        = OP_SHIFT;
      shift_din = '0;
      shift_vld = 1'b0;
    end else if (drain) begin
      op = OP_NONE;
    end else if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      case (mode)
        MODE_SHIFT:  op = OP_SHIFT;
        MODE_ROTATE: op = OP_ROTATE;
        MODE_SWAP:   op = OP_SWAP;
        default:     op = OP_NONE;
      endcase
    end
  end

  always_comb begin
    fill_d = fill_q;
    case (op)
      OP_LOAD:  fill_d = FW'(DEPTH);
      OP_SHIFT: fill_d = fill_q + FW'(shift_vld) - FW'(stage_vld[DEPTH-1]);
      default:  fill_d = fill_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (drain) done_d = 1'b1;
        else if (fill_d != '0) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (drain) state_d = ST_DRAIN;
        else if (fill_d == '0) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (fill_d == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      busy_q  <= (state_d == ST_DRAIN);
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // Swap partner is the other member of pair (2k, 2k+1); an unpaired last stage points at itself.
    localparam int PI = (i % 2 == 0) ? ((i + 1 < DEPTH) ? i + 1 : i) : i - 1;

    logic [WIDTH-1:0] prev_data, wrap_data;
    logic             prev_vld, wrap_vld;
    cell_sel_t        sel;

    if (i == 0) begin : g_head
      assign prev_data = shift_din;
      assign prev_vld  = shift_vld;
      assign wrap_data = stage_data[DEPTH-1];
      assign wrap_vld  = stage_vld[DEPTH-1];
    end else begin : g_body
      assign prev_data = stage_data[i-1];
      assign prev_vld  = stage_vld[i-1];
      assign wrap_data = stage_data[i-1];
      assign wrap_vld  = stage_vld[i-1];
    end

    always_comb begin
      case (op)
        OP_SHIFT:  sel = SEL_PREV;
        OP_ROTATE: sel = SEL_WRAP;
        OP_SWAP:   sel = (PI != i) ? SEL_PARTNER : SEL_HOLD;
        default:   sel = SEL_HOLD;
      endcase
    end

    swap_pipe_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk            (clk),
      .rst            (rst),
      .load_i         (op == OP_LOAD),
      .load_data_i    (load_data[i*WIDTH +: WIDTH]),
      .sel_i          (sel),
      .prev_data_i    (prev_data),
      .prev_vld_i     (prev_vld),
      .wrap_data_i    (wrap_data),
      .wrap_vld_i     (wrap_vld),
      .partner_data_i (stage_data[PI]),
      .partner_vld_i  (stage_vld[PI]),
      .data_o         (stage_data[i]),
      .vld_o          (stage_vld[i])
    );

    assign stages[i*WIDTH +: WIDTH] = stage_data[i];
  end

  assign dout       = stage_data[DEPTH-1];
  assign dout_valid = stage_vld[DEPTH-1];
  assign fill_count = fill_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/stage_swap_pipe.md
Name: stage_swap_pipe

Overview:
Parametrised DEPTH-stage, WIDTH-bit register pipeline that generalises the two-register clocked exchange to N stages. It supports four run-time modes (hold, shift, rotate, pairwise swap), parallel load, per-stage valid tracking, a fill counter, and a drain state machine with a completion pulse. It is the reusable register-transfer primitive for the assignment datapaths and their benches.

Parameters:
WIDTH, 8, bits per stage (>=1)
DEPTH, 4, number of stages (>=2)
RESET_VAL, 0, data value loaded into every stage on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  advance pipeline in the selected mode
mode  input  2  00 HOLD, 01 SHIFT, 10 ROTATE, 11 SWAP
din  input  WIDTH  serial input into stage 0 (SHIFT only)
din_valid  input  1  valid qualifier for din
load  input  1  parallel load request
load_data  input  WIDTH*DEPTH  stage i = bits [i*WIDTH +: WIDTH]
drain  input  1  request to flush all valid entries
stages  output  WIDTH*DEPTH  registered stage contents, same packing as load_data
dout  output  WIDTH  stage DEPTH-1 data
dout_valid  output  1  stage DEPTH-1 valid
fill_count  output  $clog2(DEPTH+1)  number of valid stages
busy  output  1  high in DRAIN
done  output  1  one-cycle pulse when a drain completes

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered or driven directly from registers.
- Reset: all stages = RESET_VAL, all valids = 0, fill_count = 0, state = IDLE, busy = 0, done = 0. Reset overrides every other input, including mid-drain.
- All stage updates take values from before the clock edge (non-blocking semantics); no stage ever sees a same-edge update.
- Priority in IDLE/RUN: rst > load > en.
- Load: stages <= load_data, all valids = 1, fill_count = DEPTH.
- en=0 or mode HOLD: no change.
- SHIFT:
  - stage[0] <= din, valid[0] <= din_valid.
  - stage[i] <= stage[i-1] for i>0; valids move with the data.
  - fill_count <= fill_count + din_valid - valid[DEPTH-1].
  - Latency: a datum reaches dout after DEPTH enabled SHIFT edges.
- ROTATE: stage[0] <= stage[DEPTH-1], stage[i] <= stage[i-1]; valids rotate with the data; fill_count unchanged.
- SWAP: pairs (2k, 2k+1) exchange data and valid. If DEPTH is odd, stage DEPTH-1 holds. fill_count unchanged.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when the next fill_count > 0.
  - RUN -> IDLE when the next fill_count = 0 and drain = 0.
  - RUN -> DRAIN when drain = 1; drain has priority over load and en on that edge, and that edge does not move data.
  - DRAIN:
    - Forced SHIFT every cycle with din = 0 and din_valid = 0; en, mode and load are ignored.
    - busy = 1.
    - On the edge where fill_count goes 1 -> 0: state <= IDLE and done <= 1 for exactly one cycle.
  - drain in IDLE: done pulses the next cycle and the state stays IDLE.
  - done is 0 at all other times.
- Boundaries:
  - SHIFT with valid in and valid out together: fill_count unchanged.
  - fill_count never exceeds DEPTH and never underflows.
  - ROTATE/SWAP on invalid stages move the invalid flags; data is still permuted.

Decomposition:
- Shared package stage_swap_pkg:
  - mode localparams MODE_HOLD/SHIFT/ROTATE/SWAP.
  - state encoding ST_IDLE/ST_RUN/ST_DRAIN.
- One natural sub-module, swap_pipe_cell: a single WIDTH-bit + valid register with a 4-way next-value mux (hold, prev, wrap, partner). The top level generates DEPTH of these and owns the FSM and fill counter.

Test Plan (WIDTH=8, DEPTH=4):
1. Reset: assert rst 2 cycles with load=1 and en=1 -> stages=0x00000000, dout_valid=0, fill_count=0, busy=0, done=0.
2. SHIFT 0x11,0x22,0x33,0x44, all valid -> stages {s3..s0} = {11,22,33,44}, dout=0x11, dout_valid=1, fill_count=4, state RUN.
3. From test 2, one SWAP edge -> {s3..s0} = {22,11,44,33}, dout=0x22, fill_count=4. A second SWAP restores test 2.
4. From test 2, ROTATE -> {s3..s0} = {22,33,44,11}, dout=0x22. After four ROTATE edges the contents equal test 2 again.
5. From test 2, pulse drain:
   - next edge: busy=1, data unchanged.
   - then dout = 22, 33, 44, then dout_valid=0.
   - fill_count 3, 2, 1, 0.
   - done=1 for exactly the one cycle after fill reaches 0, then IDLE, busy=0.
6. Mid-drain, with fill_count=2, assert rst -> all zero and IDLE next cycle, no done pulse. Then load=1, en=1, mode=SHIFT, load_data=0xA1B2C3D4 -> stages=0xA1B2C3D4, fill_count=4 (load wins over en).
